// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined borrow-lookahead subtractor: d = a - b - bin, low half in stage 1, high half in stage 2.
// Optional signed-overflow output enabled by defining CLA_SUB_OVF_EN.

module cla_sub_grp (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo
);
    logic [3:0] g, p, c;
    logic       gg, pp;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // c[i] is the borrow into bit i, all derived directly from the group borrow-in
    assign c[0] = bi;
    assign c[1] = g[0] | (p[0] & bi);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pp = &p;
    assign bo = gg | (pp & bi);
    assign d  = a ^ b ^ c;
endmodule

module cla_sub_half #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);
    localparam int NG = W / 4;
    logic [NG:0] bc;

    assign bc[0] = bi;
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_sub_grp u_grp (
            .a (a[4*gi +: 4]),
            .b (b[4*gi +: 4]),
            .bi(bc[gi]),
            .d (d[4*gi +: 4]),
            .bo(bc[gi+1])
        );
    end
    assign bo = bc[NG];
endmodule

module cla_sub_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
`ifdef CLA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int H = WIDTH / 2;

    logic         s1_valid;
    logic [H-1:0] s1_dlo, s1_ahi, s1_bhi;
    logic         s1_blo;
    logic         s1_adv, s2_adv;
    logic [H-1:0] lo_d, hi_d;
    logic         lo_b, hi_b;

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = !s1_valid | s2_adv;
    assign in_ready = s1_adv & !rst;

    cla_sub_half #(.W(H)) u_lo (
        .a (a[H-1:0]),
        .b (b[H-1:0]),
        .bi(bin),
        .d (lo_d),
        .bo(lo_b)
    );

    cla_sub_half #(.W(H)) u_hi (
        .a (s1_ahi),
        .b (s1_bhi),
        .bi(s1_blo),
        .d (hi_d),
        .bo(hi_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_dlo   <= '0;
            s1_blo   <= 1'b0;
            s1_ahi   <= '0;
            s1_bhi   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_dlo <= lo_d;
                s1_blo <= lo_b;
                s1_ahi <= a[WIDTH-1:H];
                s1_bhi <= b[WIDTH-1:H];
            end
        end
    end

    // Output data only reloads when a real beat moves in, so a bubble never clobbers held results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
            zero      <= 1'b0;
`ifdef CLA_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                d    <= {hi_d, s1_dlo};
                bout <= hi_b;
                zero <= ({hi_d, s1_dlo} == '0);
`ifdef CLA_SUB_OVF_EN
                ovf  <= (s1_ahi[H-1] != s1_bhi[H-1]) & (hi_d[H-1] != s1_ahi[H-1]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed bench for cla_sub_pipe: arithmetic reference queue checked every output cycle plus literal vectors.
module tb_cla_sub_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, bin, out_valid, out_ready, bout, zero;
    logic [31:0] a, b, d;
    logic        ovf;

    typedef struct {
        logic [31:0] d;
        logic        bout;
        logic        zero;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    logic [31:0] seen[$];
    int          nchk = 0;
    int          nerr = 0;

    cla_sub_pipe #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d        (d),
        .bout     (bout),
        .zero     (zero)
`ifdef CLA_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

`ifndef CLA_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic bi);
        exp_t        e;
        logic [32:0] r;
        r      = {1'b0, x} - {1'b0, y} - {32'd0, bi};
        e.d    = r[31:0];
        e.bout = r[32];
        e.zero = (r[31:0] == 32'd0);
        e.ovf  = (x[31] != y[31]) && (r[31] != x[31]);
        return e;
    endfunction

    // Inputs and out_ready only change just after posedge, so negedge values are what the next edge sees
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("model_d", d, q[0].d);
                    chk("model_bout", {31'd0, bout}, {31'd0, q[0].bout});
                    chk("model_zero", {31'd0, zero}, {31'd0, q[0].zero});
`ifdef CLA_SUB_OVF_EN
                    chk("model_ovf", {31'd0, ovf}, {31'd0, q[0].ovf});
`endif
                    if (out_ready) begin
                        seen.push_back(d);
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, bin));
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the posedge that accepted the beat
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic bi, output int waits);
        a = x; b = y; bin = bi; in_valid = 1'b1; waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) chk("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic one(input logic [31:0] x, input logic [31:0] y, input logic bi,
                       input logic [31:0] ed, input logic eb, input logic ez, input logic eo,
                       input string nm);
        int w, n;
        send(x, y, bi, w);
        wait_out(n);
        chk({nm, "_d"}, d, ed);
        chk({nm, "_bout"}, {31'd0, bout}, {31'd0, eb});
        chk({nm, "_zero"}, {31'd0, zero}, {31'd0, ez});
`ifdef CLA_SUB_OVF_EN
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
`endif
        if (nm == "basic") chk("latency", n, 32'd1);
        sync();
    endtask

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_d", d, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) sync();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        sync();

        one(32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, "basic");
        one(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "wrap_b");
        one(32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "wrap_bin");
        one(32'd5, 32'd4, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, "zero_bin");
        one(32'h0001_0000, 32'd1, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, "half_borrow");
        one(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, "ovf_neg");
        one(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1, "ovf_pos");

        // back-to-back stream: no wait states with out_ready held high
        for (int i = 0; i < 4; i++) begin
            send(32'd100 + i, i, i[0], w);
            if (i > 0) chk("throughput_waits", w, 32'd0);
        end
        repeat (4) sync();

        // backpressure: 6 beats, 4-cycle stall mid-stream
        seen.delete();
        fork
            begin
                for (int i = 10; i < 16; i++) send(i, 32'd1, 1'b0, w);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
                chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
                out_ready = 1'b1;
                #1;
                chk("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
            end
        join
        repeat (5) sync();
        chk("bp_count", seen.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < seen.size()) chk("bp_order", seen[i], 32'd9 + i);

        // reset with two beats in flight
        out_ready = 1'b0;
        send(32'd20, 32'd1, 1'b0, w);
        send(32'd30, 32'd1, 1'b0, w);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_d", d, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        sync();
        rst = 1'b0;
        #1;
        chk("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        seen.delete();
        sync();
        one(32'd7, 32'd2, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, "after_rst");
        repeat (4) sync();
        chk("after_rst_count", seen.size(), 32'd1);
        chk("after_rst_idle", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/cla_sub_pipe.md
# cla_sub_pipe

Pipelined 32-bit borrow-lookahead subtractor. It is the inverse-direction companion to the team's combinational carry-lookahead adder. It computes `d = a - b - bin` over two registered stages: the low half in stage 1, the high half in stage 2. Each half is built from 4-bit borrow-lookahead groups chained by a ripple borrow. Operands enter and results leave through valid/ready handshakes, so the block drops into streaming datapaths next to the adder and sustains one result per cycle.

## Interface
- `WIDTH`, default 32: operand/result width. Must be a multiple of 8; each pipeline half is `WIDTH/2` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block accepts an operand beat this cycle.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  downstream accepts the result.
- `d`  out  WIDTH  difference, `a - b - bin` mod 2^WIDTH.
- `bout`  out  1  borrow-out; 1 iff unsigned `a < b + bin`.
- `zero`  out  1  `d == 0`.
- `ovf`  out  1  signed overflow (present only with `CLA_SUB_OVF_EN`).

## Operation
- Group logic, per 4-bit group:
  - generate `g = ~a & b`
  - propagate `p = ~(a ^ b)`
  - group borrow `B_out = G | (P & B_in)`
  - internal borrows are computed lookahead-style from `g`, `p` and the group borrow-in.
  - Groups ripple their borrow within a half.
- Stage 1 (on accept):
  - registers low-half difference and low-half borrow-out;
  - registers the high halves of `a` and `b`;
  - registers `s1_valid`.
- Stage 2 (on advance):
  - computes the high-half difference from the registered high operands, using the registered low borrow as borrow-in;
  - registers full `d`, `bout`, `zero` and `ovf`, and sets `out_valid`.
- Handshake:
  - a transfer occurs when valid and ready are both 1 on a rising edge.
  - `s2_adv = !out_valid | out_ready`
  - `s1_adv = !s1_valid | s2_adv`
  - `in_ready = s1_adv & !rst` (combinational).
- Stall: while `out_valid & !out_ready`, the outputs `d`, `bout`, `zero` and `ovf` hold stable. Stage 1 holds its contents if it is occupied.
- Ordering: results leave in acceptance order. The pipeline never drops or duplicates a beat.
- Simultaneous events:
  - output drain and input accept in the same cycle are both legal;
  - a full pipeline with `out_ready=1` still shows `in_ready=1`.
- Reset: asynchronous and mid-operation safe. Every in-flight beat is discarded.
- Reset values:
  - `out_valid=0`, `d=0`, `bout=0`, `zero=0`, `ovf=0`;
  - internal `s1_valid=0`;
  - `in_ready=0` while `rst` is asserted, and 1 on the first cycle after release.
- Width rule: internal arithmetic uses `WIDTH/2` bits plus one borrow bit per half. There is no sign extension; `bout` is the final borrow.

## Timing
- Latency: 2 cycles. A beat accepted at edge N shows `out_valid=1` after edge N+1, given no stall.
- Throughput: 1 beat/cycle with `out_ready` held at 1.
- Capacity: 2 beats in flight (stage 1 plus output register).
  - With `out_ready=0`, `in_ready` drops after 2 beats are accepted into an empty pipeline.
  - It returns to 1 in the same cycle that `out_ready` rises.
- Critical path: `WIDTH/8` ripple-chained 4-bit lookahead groups per stage.

## Configuration
- `CLA_SUB_OVF_EN` defined:
  - port `ovf` exists;
  - `ovf = (a[W-1] != b[W-1]) & (d[W-1] != a[W-1])`, registered in stage 2;
  - the stage-1 path also carries the operand MSBs for this term.
- `CLA_SUB_OVF_EN` undefined:
  - no `ovf` port and no overflow logic;
  - all other behaviour is identical.

## Test plan
- Basic subtract: `a=5`, `b=3`, `bin=0`, `out_ready=1` -> 2 cycles later `d=0x00000002`, `bout=0`, `zero=0`.
- Wrap-around: `a=0`, `b=1`, `bin=0` -> `d=0xFFFFFFFF`, `bout=1`. Then `a=0`, `b=0`, `bin=1` -> `d=0xFFFFFFFF`, `bout=1`.
- Zero flag and borrow-in: `a=5`, `b=4`, `bin=1` -> `d=0`, `zero=1`, `bout=0`.
- Half-boundary borrow and overflow:
  - `a=0x00010000`, `b=0x00000001` -> `d=0x0000FFFF`.
  - `a=0x80000000`, `b=1` -> `d=0x7FFFFFFF`; with `CLA_SUB_OVF_EN`, `ovf=1`.
- Backpressure: stream 6 beats (`a=10..15`, `b=1`) with `out_ready=0` for 4 cycles mid-stream. Required response:
  - `in_ready=0` once 2 beats are held;
  - held `d` is stable;
  - outputs are 9..14 in order with none lost.
- Reset mid-operation: assert `rst` with 2 beats in flight -> `out_valid=0` and `d=0` immediately, without waiting for a clock edge. After release, the first new beat `a=7`, `b=2` yields `d=5` only.
